fix_length_packet_framer: RTL and testbench

Downstream neighbour of the fixed-length bytes-to-packets stage. Buffers 32-bit Avalon-ST packet words in a small FIFO and re-serialises each packet into an 8-bit Avalon-ST byte stream framed as preamble, sync byte, payload and a CRC-16 trailer. It feeds the modulator-side byte interface. It tolerates an upstream that ignores ready by absorbing words in the FIFO and flagging overflow.

---
 rtl/fix_length_packet_framer.sv | 212 +++++++++++++++++++++
 tb/tb_fix_length_packet_framer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fix_length_packet_framer.sv
// Word FIFO plus byte serialiser: frames each 32-bit packet as preamble, sync,
// payload bytes and a CRC-16/CCITT-FALSE trailer on an 8-bit Avalon-ST source.
module fix_length_packet_framer #(
  parameter int          FIFO_DEPTH    = 8,
  parameter int          PREAMBLE_LEN  = 4,
  parameter logic [7:0]  PREAMBLE_BYTE = 8'h55,
  parameter logic [7:0]  SYNC_BYTE     = 8'hD5
) (
  input  logic        clock_clk,
  input  logic        reset_reset,
  input  logic [31:0] asi_in0_data,
  input  logic        asi_in0_valid,
  output logic        asi_in0_ready,
  input  logic        asi_in0_startofpacket,
  input  logic        asi_in0_endofpacket,
  output logic [7:0]  aso_out0_data,
  output logic        aso_out0_valid,
  input  logic        aso_out0_ready,
  output logic        aso_out0_startofpacket,
  output logic        aso_out0_endofpacket,
  output logic        status_overflow,
  output logic [15:0] status_drop_count
);

  localparam int         AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0] LAST_PRE   = 4'(PREAMBLE_LEN - 1);

  typedef enum logic [2:0] {IDLE, PREAMBLE, SYNC, PAYLOAD, CRC_HI, CRC_LO} state_t;

  logic [33:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [AW:0]   count_q, count_d;
  logic          ready_q, overflow_q;
  logic          full, empty, push, pop, advance, lastByte;
  logic [33:0]   head;

  state_t      state_q;
  logic [31:0] word_q;
  logic        wordEop_q, haveWord_q;
  logic [1:0]  idx_q;
  logic [3:0]  preCnt_q;
  logic [15:0] crc_q, drop_q;
  logic [7:0]  outData_q, payByte;
  logic        outValid_q, outSop_q, outEop_q;

  function automatic logic [15:0] crcByte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  assign full     = (count_q == FULL_COUNT);
  assign empty    = (count_q == '0);
  assign head     = mem_q[rdPtr_q];
  assign advance  = !outValid_q || aso_out0_ready;
  assign lastByte = (idx_q == 2'd3);
  assign push     = asi_in0_valid && (!full || pop);
  assign count_d  = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  // The FSM consumes the FIFO head exactly when its own state update takes it.
  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      case (state_q)
        IDLE:    pop = 1'b1;
        PAYLOAD: pop = !haveWord_q || (advance && lastByte && !wordEop_q);
        default: pop = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (idx_q)
      2'd0:    payByte = word_q[31:24];
      2'd1:    payByte = word_q[23:16];
      2'd2:    payByte = word_q[15:8];
      default: payByte = word_q[7:0];
    endcase
  end

  always_ff @(posedge clock_clk) begin
    if (push) mem_q[wrPtr_q] <= {asi_in0_startofpacket, asi_in0_endofpacket, asi_in0_data};
  end

  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      ready_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      count_q <= count_d;
      ready_q <= (count_d != FULL_COUNT);
      if (asi_in0_valid && full && !pop) overflow_q <= 1'b1;
    end
  end

  // Output registers are reloaded only when the current byte has been taken
  // (or nothing is presented), so the CRC covers exactly the bytes emitted.
  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q    <= IDLE;
      word_q     <= '0;
      wordEop_q  <= 1'b0;
      haveWord_q <= 1'b0;
      idx_q      <= '0;
      preCnt_q   <= '0;
      crc_q      <= 16'hFFFF;
      drop_q     <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
      outSop_q   <= 1'b0;
      outEop_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (advance) begin
            outValid_q <= 1'b0;
            outSop_q   <= 1'b0;
            outEop_q   <= 1'b0;
          end
          if (!empty) begin
            if (head[33]) begin
              word_q     <= head[31:0];
              wordEop_q  <= head[32];
              haveWord_q <= 1'b1;
              preCnt_q   <= '0;
              state_q    <= PREAMBLE;
            end else if (drop_q != 16'hFFFF) begin
              drop_q <= drop_q + 16'd1;
            end
          end
        end
        PREAMBLE: if (advance) begin
          outData_q  <= PREAMBLE_BYTE;
          outValid_q <= 1'b1;
          outSop_q   <= (preCnt_q == 4'd0);
          outEop_q   <= 1'b0;
          preCnt_q   <= preCnt_q + 4'd1;
          if (preCnt_q == LAST_PRE) state_q <= SYNC;
        end
        SYNC: if (advance) begin
          outData_q  <= SYNC_BYTE;
          outValid_q <= 1'b1;
          outSop_q   <= 1'b0;
          outEop_q   <= 1'b0;
          crc_q      <= 16'hFFFF;
          idx_q      <= '0;
          state_q    <= PAYLOAD;
        end
        PAYLOAD: begin
          if (haveWord_q) begin
            if (advance) begin
              outData_q  <= payByte;
              outValid_q <= 1'b1;
              outSop_q   <= 1'b0;
              outEop_q   <= 1'b0;
              crc_q      <= crcByte(crc_q, payByte);
              idx_q      <= idx_q + 2'd1;
              if (lastByte) begin
                if (wordEop_q) begin
                  state_q <= CRC_HI;
                end else if (!empty) begin
                  word_q    <= head[31:0];
                  wordEop_q <= head[32];
                end else begin
                  haveWord_q <= 1'b0;
                end
              end
            end
          end else begin
            if (advance) outValid_q <= 1'b0;
            if (!empty) begin
              word_q     <= head[31:0];
              wordEop_q  <= head[32];
              haveWord_q <= 1'b1;
            end
          end
        end
        CRC_HI: if (advance) begin
          outData_q  <= crc_q[15:8];
          outValid_q <= 1'b1;
          outSop_q   <= 1'b0;
          outEop_q   <= 1'b0;
          state_q    <= CRC_LO;
        end
        CRC_LO: if (advance) begin
          outData_q  <= crc_q[7:0];
          outValid_q <= 1'b1;
          outSop_q   <= 1'b0;
          outEop_q   <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign asi_in0_ready          = ready_q;
  assign aso_out0_data          = outData_q;
  assign aso_out0_valid         = outValid_q;
  assign aso_out0_startofpacket = outSop_q;
  assign aso_out0_endofpacket   = outEop_q;
  assign status_overflow        = overflow_q;
  assign status_drop_count      = drop_q;

endmodule

// File: tb/tb_fix_length_packet_framer.sv
// Self-checking bench for fix_length_packet_framer: table-driven frames with
// random data against a queue-based frame model, plus drop/overflow/reset sequences.
module tb_fix_length_packet_framer;

  localparam int         FIFO_DEPTH   = 8;
  localparam int         PREAMBLE_LEN = 4;
  localparam logic [7:0] PRE_BYTE     = 8'h55;
  localparam logic [7:0] SYNC_BYTE    = 8'hD5;

  logic        clock_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic [31:0] asi_in0_data = '0;
  logic        asi_in0_valid = 1'b0;
  logic        asi_in0_ready;
  logic        asi_in0_startofpacket = 1'b0;
  logic        asi_in0_endofpacket = 1'b0;
  logic [7:0]  aso_out0_data;
  logic        aso_out0_valid;
  logic        aso_out0_ready = 1'b1;
  logic        aso_out0_startofpacket;
  logic        aso_out0_endofpacket;
  logic        status_overflow;
  logic [15:0] status_drop_count;

  fix_length_packet_framer #(
    .FIFO_DEPTH(FIFO_DEPTH), .PREAMBLE_LEN(PREAMBLE_LEN),
    .PREAMBLE_BYTE(PRE_BYTE), .SYNC_BYTE(SYNC_BYTE)
  ) dut (
    .clock_clk(clock_clk), .reset_reset(reset_reset),
    .asi_in0_data(asi_in0_data), .asi_in0_valid(asi_in0_valid), .asi_in0_ready(asi_in0_ready),
    .asi_in0_startofpacket(asi_in0_startofpacket), .asi_in0_endofpacket(asi_in0_endofpacket),
    .aso_out0_data(aso_out0_data), .aso_out0_valid(aso_out0_valid), .aso_out0_ready(aso_out0_ready),
    .aso_out0_startofpacket(aso_out0_startofpacket), .aso_out0_endofpacket(aso_out0_endofpacket),
    .status_overflow(status_overflow), .status_drop_count(status_drop_count)
  );

  always #5 clock_clk = ~clock_clk;

  typedef struct {
    int nWords;
    int gap;
    int rdyMode;
    bit fixedData;
    int expLen;
  } vec_t;

  int          checksRun = 0;
  int          checksPassed = 0;
  int          readyMode = 0;
  logic [9:0]  rxQ[$];
  logic [9:0]  expQ[$];
  logic [31:0] modelWords[$];
  logic        holdPending = 1'b0;
  logic [10:0] heldOut = '0;
  vec_t        vecs[6];

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checksRun++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Bit-serial CRC-16/CCITT-FALSE step, one message bit at a time.
  function automatic logic [15:0] crcStep(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int k = 7; k >= 0; k--) begin
      fb = r[15] ^ b[k];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  // Sink ready pattern: 0 always, 1 toggling, 2 random, 3 held low.
  always @(posedge clock_clk) begin
    #1;
    case (readyMode)
      0:       aso_out0_ready = 1'b1;
      1:       aso_out0_ready = !aso_out0_ready;
      2:       aso_out0_ready = 1'($urandom_range(0, 1));
      default: aso_out0_ready = 1'b0;
    endcase
  end

  always @(negedge clock_clk) begin
    if (reset_reset) begin
      holdPending = 1'b0;
    end else begin
      if (holdPending)
        checkVal("hold stable", {21'd0, aso_out0_valid, aso_out0_startofpacket, aso_out0_endofpacket, aso_out0_data},
                 {21'd0, heldOut});
      if (aso_out0_valid && aso_out0_ready)
        rxQ.push_back({aso_out0_startofpacket, aso_out0_endofpacket, aso_out0_data});
      holdPending = aso_out0_valid && !aso_out0_ready;
      heldOut     = {aso_out0_valid, aso_out0_startofpacket, aso_out0_endofpacket, aso_out0_data};
    end
  end

  task automatic modelFrame();
    logic [15:0] crc;
    logic [7:0]  b;
    logic [31:0] w;
    crc = 16'hFFFF;
    for (int i = 0; i < PREAMBLE_LEN; i++) expQ.push_back({(i == 0) ? 1'b1 : 1'b0, 1'b0, PRE_BYTE});
    expQ.push_back({2'b00, SYNC_BYTE});
    foreach (modelWords[i]) begin
      w = modelWords[i];
      for (int k = 3; k >= 0; k--) begin
        b   = w[8*k +: 8];
        crc = crcStep(crc, b);
        expQ.push_back({2'b00, b});
      end
    end
    expQ.push_back({2'b00, crc[15:8]});
    expQ.push_back({2'b01, crc[7:0]});
    modelWords.delete();
  endtask

  task automatic pushWord(input logic [31:0] data, input logic sop, input logic eop, input bit waitReady);
    int t;
    t = 0;
    while (waitReady && !asi_in0_ready && t < 2000) begin
      @(posedge clock_clk); #1;
      t++;
    end
    if (t >= 2000) checkVal("input ready timeout", 32'd0, 32'd1);
    asi_in0_data          = data;
    asi_in0_startofpacket = sop;
    asi_in0_endofpacket   = eop;
    asi_in0_valid         = 1'b1;
    @(posedge clock_clk); #1;
    asi_in0_valid         = 1'b0;
    asi_in0_startofpacket = 1'b0;
    asi_in0_endofpacket   = 1'b0;
  endtask

  task automatic applyStimulus(input int n, input int gap, input bit fixedData);
    logic [31:0] w[$];
    logic [31:0] x;
    for (int i = 0; i < n; i++) begin
      x = fixedData ? (32'h01020304 + 32'h04040404 * 32'(i)) : $urandom();
      w.push_back(x);
      modelWords.push_back(x);
    end
    modelFrame();
    for (int i = 0; i < n; i++) begin
      pushWord(w[i], (i == 0), (i == n - 1), 1'b1);
      repeat (gap) begin @(posedge clock_clk); #1; end
    end
  endtask

  task automatic checkOutput(input string name, input int expLen, input bit residue);
    int          t;
    int          bad;
    logic [15:0] crc;
    t = 0;
    while (rxQ.size() < expQ.size() && t < 20000) begin
      @(posedge clock_clk); #1;
      t++;
    end
    repeat (10) @(posedge clock_clk);
    #1;
    checkVal({name, " length"}, rxQ.size(), expLen);
    bad = -1;
    for (int i = 0; i < rxQ.size() && i < expQ.size(); i++)
      if (bad < 0 && rxQ[i] !== expQ[i]) bad = i;
    checkVal({name, " first bad byte index"}, bad, -1);
    if (residue) begin
      crc = 16'hFFFF;
      for (int i = PREAMBLE_LEN + 1; i < rxQ.size(); i++) crc = crcStep(crc, rxQ[i][7:0]);
      checkVal({name, " crc residue"}, {16'd0, crc}, 32'd0);
    end
    rxQ.delete();
    expQ.delete();
  endtask

  task automatic doReset();
    reset_reset = 1'b1;
    repeat (3) @(posedge clock_clk);
    #1;
    reset_reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{nWords: 2,  gap: 0, rdyMode: 0, fixedData: 1'b1, expLen: 15};
    vecs[1] = '{nWords: 2,  gap: 0, rdyMode: 1, fixedData: 1'b1, expLen: 15};
    vecs[2] = '{nWords: 65, gap: 4, rdyMode: 0, fixedData: 1'b0, expLen: 267};
    vecs[3] = '{nWords: 1,  gap: 0, rdyMode: 0, fixedData: 1'b0, expLen: 11};
    vecs[4] = '{nWords: 3,  gap: 0, rdyMode: 2, fixedData: 1'b0, expLen: 19};
    vecs[5] = '{nWords: 5,  gap: 2, rdyMode: 2, fixedData: 1'b0, expLen: 27};

    repeat (3) @(posedge clock_clk);
    #1;
    checkVal("reset data", {24'd0, aso_out0_data}, 32'd0);
    checkVal("reset valid", {31'd0, aso_out0_valid}, 32'd0);
    checkVal("reset sop", {31'd0, aso_out0_startofpacket}, 32'd0);
    checkVal("reset eop", {31'd0, aso_out0_endofpacket}, 32'd0);
    checkVal("reset in ready", {31'd0, asi_in0_ready}, 32'd1);
    checkVal("reset overflow", {31'd0, status_overflow}, 32'd0);
    checkVal("reset drop count", {16'd0, status_drop_count}, 32'd0);
    reset_reset = 1'b0;
    repeat (2) @(posedge clock_clk);
    #1;

    for (int v = 0; v < 6; v++) begin
      readyMode = vecs[v].rdyMode;
      applyStimulus(vecs[v].nWords, vecs[v].gap, vecs[v].fixedData);
      checkOutput($sformatf("vec%0d", v), vecs[v].expLen, 1'b1);
      checkVal($sformatf("vec%0d overflow", v), {31'd0, status_overflow}, 32'd0);
      checkVal($sformatf("vec%0d drop count", v), {16'd0, status_drop_count}, 32'd0);
      readyMode = 0;
    end

    // Words outside a packet are dropped, then a normal packet follows.
    for (int i = 0; i < 3; i++) pushWord($urandom(), 1'b0, 1'b0, 1'b1);
    applyStimulus(2, 0, 1'b0);
    checkOutput("after drops", 15, 1'b1);
    checkVal("drop count", {16'd0, status_drop_count}, 32'd3);

    // Overflow: stall the sink in the preamble, then push 9 words blindly.
    readyMode = 3;
    modelWords.push_back(32'hA1A2A3A4);
    modelFrame();
    pushWord(32'hA1A2A3A4, 1'b1, 1'b1, 1'b1);
    begin
      int t;
      t = 0;
      while (!aso_out0_valid && t < 100) begin @(posedge clock_clk); #1; t++; end
      checkVal("stall reached preamble", {31'd0, aso_out0_valid}, 32'd1);
    end
    for (int i = 0; i < 8; i++) modelWords.push_back(32'hB0000000 + 32'(i));
    modelFrame();
    for (int i = 0; i < 9; i++)
      pushWord(32'hB0000000 + 32'(i), (i == 0) || (i == 8), (i >= 7), 1'b0);
    checkVal("overflow set", {31'd0, status_overflow}, 32'd1);
    checkVal("in ready while full", {31'd0, asi_in0_ready}, 32'd0);
    readyMode = 0;
    checkOutput("overflow frames", 50, 1'b0);
    checkVal("overflow sticky", {31'd0, status_overflow}, 32'd1);
    doReset();
    checkVal("overflow cleared by reset", {31'd0, status_overflow}, 32'd0);
    checkVal("drop cleared by reset", {16'd0, status_drop_count}, 32'd0);

    // Reset in the middle of the payload, then a fresh one-word packet.
    applyStimulus(4, 0, 1'b0);
    begin
      int t;
      t = 0;
      while (rxQ.size() < 7 && t < 200) begin @(posedge clock_clk); #1; t++; end
      checkVal("reached payload", {31'd0, (rxQ.size() >= 7) ? 1'b1 : 1'b0}, 32'd1);
    end
    #3;
    reset_reset = 1'b1;
    #1;
    checkVal("mid reset data", {24'd0, aso_out0_data}, 32'd0);
    checkVal("mid reset valid", {31'd0, aso_out0_valid}, 32'd0);
    checkVal("mid reset sop", {31'd0, aso_out0_startofpacket}, 32'd0);
    checkVal("mid reset eop", {31'd0, aso_out0_endofpacket}, 32'd0);
    checkVal("mid reset in ready", {31'd0, asi_in0_ready}, 32'd1);
    repeat (2) @(posedge clock_clk);
    #1;
    reset_reset = 1'b0;
    rxQ.delete();
    expQ.delete();
    applyStimulus(1, 0, 1'b0);
    checkOutput("post reset frame", 11, 1'b1);

    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end

endmodule
